// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler: per-channel pending counters feed a
// round-robin arbiter that drives one registered valid/ready event port.
module edge_event_arbiter #(
   parameter  int N_CH  = 4,
   parameter  int CNT_W = 2,
   localparam int ID_W  = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N_CH-1:0] din,
   output logic            evt_valid,
   output logic [ID_W-1:0] evt_id,
   input  logic            evt_ready,
   output logic [N_CH-1:0] ovf,
   input  logic [N_CH-1:0] ovf_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_CH-1:0]  din_q;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  ovf_set;
   logic [CNT_W-1:0] pend_cnt [N_CH];
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  pick_nxt;
   logic [ID_W:0]    idx;
   logic             pick_found;
   logic             load_en;

   assign rise    = din & ~din_q;
   assign load_en = ~evt_valid | evt_ready;

   // Search starts at rr_ptr and wraps; counts are registered, so an edge
   // counted this cycle only becomes eligible on the next one.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = '0;
      for (int j = 0; j < N_CH; j++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(j);
         if (idx >= (ID_W+1)'(N_CH)) idx = idx - (ID_W+1)'(N_CH);
         if (!pick_found && (pend_cnt[idx[ID_W-1:0]] != '0)) begin
            pick_found = 1'b1;
            pick_id    = idx[ID_W-1:0];
         end
      end
   end

   assign pick_nxt = (pick_id == ID_W'(N_CH-1)) ? '0 : pick_id + 1'b1;

   always_comb begin
      grant = '0;
      if (load_en && pick_found) grant[pick_id] = 1'b1;
   end

   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < N_CH; i++)
         ovf_set[i] = rise[i] & ~grant[i] & (pend_cnt[i] == CNT_MAX);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         din_q <= '0;
      end else begin
         din_q <= din;
      end
   end

   // A simultaneous edge and grant cancel out, so a full counter never loses it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_CH; i++) pend_cnt[i] <= '0;
         ovf <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            case ({rise[i], grant[i]})
               2'b10:   if (pend_cnt[i] != CNT_MAX) pend_cnt[i] <= pend_cnt[i] + 1'b1;
               2'b01:   pend_cnt[i] <= pend_cnt[i] - 1'b1;
               default: pend_cnt[i] <= pend_cnt[i];
            endcase
         end
         ovf <= ovf_set | (ovf & ~ovf_clr);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         evt_valid <= pick_found;
         if (pick_found) begin
            evt_id <= pick_id;
            rr_ptr <= pick_nxt;
         end
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a count-based reference model
// pushes accepted event ids; a monitor pops them on each DUT handshake.
module tb_edge_event_arbiter;

   localparam int N    = 4;
   localparam int MAXC = 3;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] din;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_ready;
   logic [3:0] ovf;
   logic [3:0] ovf_clr;

   int n_checks = 0;
   int n_fail   = 0;

   int exp_q [$];

   int       m_cnt [N];
   bit [3:0] m_prev  = '0;
   bit [3:0] m_ovf   = '0;
   bit       m_valid = 1'b0;
   int       m_id    = 0;
   int       m_rr    = 0;

   edge_event_arbiter #(.N_CH(4), .CNT_W(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .din       (din),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: integer counts, explicit round-robin scan.
   initial begin
      int  grant;
      int  k;
      bit  load;
      bit  rise;
      bit  setb;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_prev = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_rr = 0;
         end else begin
            if (m_valid && evt_ready) exp_q.push_back(m_id);
            load  = !m_valid || evt_ready;
            grant = -1;
            if (load) begin
               for (int j = 0; j < N; j++) begin
                  k = (m_rr + j) % N;
                  if (grant < 0 && m_cnt[k] > 0) grant = k;
               end
               if (grant >= 0) begin
                  m_valid = 1'b1; m_id = grant; m_rr = (grant + 1) % N;
               end else begin
                  m_valid = 1'b0;
               end
            end
            for (int i = 0; i < N; i++) begin
               rise = din[i] && !m_prev[i];
               setb = 1'b0;
               if (rise && grant != i) begin
                  if (m_cnt[i] == MAXC) setb = 1'b1;
                  else m_cnt[i]++;
               end else if (!rise && grant == i) begin
                  m_cnt[i]--;
               end
               if (setb) m_ovf[i] = 1'b1;
               else if (ovf_clr[i]) m_ovf[i] = 1'b0;
            end
            m_prev = din;
         end
      end
   end

   // Monitor: a handshake seen before a posedge is popped after it.
   initial begin
      bit       pend_hs = 1'b0;
      int       pend_id = 0;
      forever begin
         @(negedge clk);
         if (pend_hs) begin
            chk("hs_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("hs_evt_id", pend_id, exp_q.pop_front());
         end
         chk("evt_valid", int'(evt_valid), int'(m_valid));
         if (m_valid) chk("evt_id_presented", int'(evt_id), m_id);
         chk("ovf", int'(ovf), int'(m_ovf));
         pend_hs = evt_valid && evt_ready;
         pend_id = int'(evt_id);
      end
   end

   task automatic step(input logic [3:0] d, input logic r, input logic [3:0] c);
      din = d; evt_ready = r; ovf_clr = c;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(4'b0000, r, 4'b0000);
   endtask

   initial begin
      resetn = 1'b1; din = '0; evt_ready = 1'b0; ovf_clr = '0;
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_valid", int'(evt_valid), 0);
      chk("reset_ovf", int'(ovf), 0);
      resetn = 1'b1;

      // single pulse
      step(4'b0001, 1'b1, 4'b0000);
      idle(5, 1'b1);
      // all channels at once, then ch1+ch3
      step(4'b1111, 1'b1, 4'b0000);
      idle(6, 1'b1);
      step(4'b1010, 1'b1, 4'b0000);
      idle(4, 1'b1);
      // back-pressure with three ch2 pulses
      for (int i = 0; i < 3; i++) begin
         step(4'b0100, 1'b0, 4'b0000);
         step(4'b0000, 1'b0, 4'b0000);
      end
      chk("bp_valid_held", int'(evt_valid), 1);
      chk("bp_id_held", int'(evt_id), 2);
      idle(6, 1'b1);
      // saturation and sticky overflow on ch1
      for (int i = 0; i < 5; i++) begin
         step(4'b0010, 1'b0, 4'b0000);
         step(4'b0000, 1'b0, 4'b0000);
      end
      chk("sat_ovf", int'(ovf), 2);
      idle(8, 1'b1);
      chk("ovf_sticky", int'(ovf), 2);
      step(4'b0000, 1'b1, 4'b0010);
      idle(1, 1'b1);
      chk("ovf_cleared", int'(ovf), 0);
      // level held high
      for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, 4'b0000);
      idle(4, 1'b1);
      // reset with events pending
      step(4'b0001, 1'b0, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000);
      step(4'b0010, 1'b0, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000);
      step(4'b0100, 1'b0, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000);
      chk("pre_reset_valid", int'(evt_valid), 1);
      resetn = 1'b0;
      #1;
      chk("async_reset_valid", int'(evt_valid), 0);
      idle(2, 1'b1);
      resetn = 1'b1;
      idle(6, 1'b1);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [3:0] d;
         logic       r;
         logic [3:0] c;
         d = 4'($urandom);
         r = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
         step(d, r, c);
      end
      step(4'b0000, 1'b1, 4'b1111);
      idle(24, 1'b1);
      chk("drain_valid", int'(evt_valid), 0);
      chk("drain_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
